// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: opcode constants and FSM state encoding shared by the DMA engine.
package mem_dma_pkg;

    typedef logic [1:0] op_t;
    localparam op_t OP_READ  = 2'b00;
    localparam op_t OP_WRITE = 2'b01;
    localparam op_t OP_COPY  = 2'b10;
    localparam op_t OP_FILL  = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mem_dma.sv
// mem_dma: single-port memory engine executing READ / WRITE / COPY / FILL commands.
// One memory access per cycle; the memory writes on the falling clock edge, so every
// memory-facing output is a flop that settles right after the rising edge.
// Optional FILL support is built when MEM_DMA_FILL_EN is defined; otherwise opcode 11
// completes immediately without touching memory.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [7:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state;
    op_t               op;      // opcode latched at acceptance
    logic [ADDR_W-1:0] src;     // next COPY source address
    logic [ADDR_W-1:0] dst;     // next COPY/FILL destination address
    logic [7:0]        cnt;     // bytes still to be written, including the current one

    // Command FSM; all outputs are registered alongside the state. mem_we and
    // rsp_valid default low so they can only be single-cycle in their states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            op          <= OP_READ;
            src         <= '0;
            dst         <= '0;
            cnt         <= '0;
        end else begin
            rsp_valid <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        op        <= cmd_op;
                        cnt       <= cmd_len;
                        case (cmd_op)
                            OP_READ: begin
                                state       <= ST_RD;
                                mem_address <= cmd_addr;
                            end
                            OP_WRITE: begin
                                state       <= ST_WR;
                                mem_we      <= 1'b1;
                                mem_address <= cmd_addr;
                                mem_data_in <= cmd_wdata;
                                cnt         <= 8'd0;
                            end
                            OP_COPY: begin
                                if (cmd_len == 8'd0) begin
                                    state     <= ST_DONE;
                                    rsp_valid <= 1'b1;
                                end else begin
                                    state       <= ST_RD;
                                    mem_address <= cmd_addr;
                                    src         <= cmd_addr + ADDR_W'(1);
                                    dst         <= cmd_dst;
                                end
                            end
                            default: begin
`ifdef MEM_DMA_FILL_EN
                                // mem_data_in holds the fill value for the whole run
                                if (cmd_len == 8'd0) begin
                                    state     <= ST_DONE;
                                    rsp_valid <= 1'b1;
                                end else begin
                                    state       <= ST_WR;
                                    mem_we      <= 1'b1;
                                    mem_address <= cmd_addr;
                                    mem_data_in <= cmd_wdata;
                                    dst         <= cmd_addr + ADDR_W'(1);
                                end
`else
                                state     <= ST_DONE;
                                rsp_valid <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                ST_RD: begin
                    // rsp_rdata always tracks the most recent byte read
                    rsp_rdata <= mem_data_out;
                    if (op == OP_COPY) begin
                        state       <= ST_WR;
                        mem_we      <= 1'b1;
                        mem_address <= dst;
                        mem_data_in <= mem_data_out;
                        dst         <= dst + ADDR_W'(1);
                    end else begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_WR: begin
                    cnt <= cnt - 8'd1;
                    if (op == OP_COPY && cnt != 8'd1) begin
                        state       <= ST_RD;
                        mem_address <= src;
                        src         <= src + ADDR_W'(1);
                    end
`ifdef MEM_DMA_FILL_EN
                    else if (op == OP_FILL && cnt != 8'd1) begin
                        mem_we      <= 1'b1;
                        mem_address <= dst;
                        dst         <= dst + ADDR_W'(1);
                    end
`endif
                    else begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed bench for mem_dma. A byte-array memory model sits on the memory
// port; a command-level reference (ref_mem, expected write list, response timing) is
// updated at acceptance and compared against the DUT on every falling edge.
// Cycle labels: the cycle right after the accepting edge counts as 1.
module tb_mem_dma;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_addr = 8'd0, cmd_dst = 8'd0, cmd_len = 8'd0, cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] mem_address, mem_data_in, mem_data_out;
    logic       mem_we;

    mem_dma #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // memory attached to the DUT
    logic [7:0] mem [256];
    assign mem_data_out = mem[mem_address];
    always @(negedge clk) if (mem_we) mem[mem_address] <= mem_data_in;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference state
    logic [7:0]  ref_mem [256];
    logic [15:0] wq [$];
    logic [15:0] w;
    logic [7:0]  exp_rdata = 8'd0;
    int exp_rsp = -10, busy_from = -10, busy_to = -10;
    int last_rsp = -1;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle compare against the reference
    always @(negedge clk) begin
        chk("rsp_valid", int'(rsp_valid), int'(cyc == exp_rsp));
        chk("cmd_ready", int'(cmd_ready), int'(!(cyc >= busy_from && cyc <= busy_to)));
        if (rsp_valid) begin
            chk("rsp_rdata", int'(rsp_rdata), int'(exp_rdata));
            last_rsp = cyc;
        end
        if (mem_we) begin
            chk("write_expected", int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", int'(mem_address), int'(w[15:8]));
                chk("wr_data", int'(mem_data_in), int'(w[7:0]));
            end
        end
    end

    // command-level effect and timing (lat = cycle label of the response)
    task automatic model(input logic [1:0] op, input logic [7:0] a, d, len, wd, input int n);
        int lat;
        logic [7:0] b;
        case (op)
            2'd0: begin exp_rdata = ref_mem[a]; lat = 2; end
            2'd1: begin ref_mem[a] = wd; wq.push_back({a, wd}); lat = 2; end
            2'd2: begin
                for (int i = 0; i < int'(len); i++) begin
                    b = ref_mem[8'(int'(a) + i)];
                    ref_mem[8'(int'(d) + i)] = b;
                    wq.push_back({8'(int'(d) + i), b});
                    exp_rdata = b;
                end
                lat = (len == 8'd0) ? 1 : 2 * int'(len) + 1;
            end
            default: begin
`ifdef MEM_DMA_FILL_EN
                for (int i = 0; i < int'(len); i++) begin
                    ref_mem[8'(int'(a) + i)] = wd;
                    wq.push_back({8'(int'(a) + i), wd});
                end
                lat = (len == 8'd0) ? 1 : int'(len) + 1;
`else
                lat = 1;
`endif
            end
        endcase
        busy_from = n;
        busy_to   = n + lat - 1;
        exp_rsp   = n + lat - 1;
    endtask

    // present a command once ready; n = cyc value of the cycle after acceptance
    task automatic issue(input logic [1:0] op, input logic [7:0] a, d, len, wd, output int n);
        for (int k = 0; k < 50 && !cmd_ready; k++) begin @(posedge clk); #1; end
        chk("ready_before_issue", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_dst = d; cmd_len = len; cmd_wdata = wd;
        @(posedge clk); #1;
        n = cyc;
        // scramble fields: the DUT must work from its latched copy
        cmd_valid = 1'b0; cmd_op = ~op; cmd_addr = ~a; cmd_dst = ~d; cmd_len = ~len; cmd_wdata = ~wd;
    endtask

    task automatic run(input logic [1:0] op, input logic [7:0] a, d, len, wd, output int n);
        issue(op, a, d, len, wd, n);
        model(op, a, d, len, wd, n);
        for (int k = 0; k < 600 && cyc <= exp_rsp; k++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
    endtask

    initial begin
        int n, diff;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[2] = 8'h7F; ref_mem[2] = 8'h7F;
        #1 rst = 1'b1;
        #1;
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_mem_we", int'(mem_we), 0);
        chk("reset_mem_address", int'(mem_address), 0);
        chk("reset_mem_data_in", int'(mem_data_in), 0);
        chk("reset_rsp_rdata", int'(rsp_rdata), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // READ 0x02
        run(2'd0, 8'h02, 8'h00, 8'h00, 8'h00, n);
        chk("read_latency", last_rsp - n + 1, 2);
        chk("read_rdata", int'(rsp_rdata), 8'h7F);

        // WRITE 0x10 = A5, then READ it back
        run(2'd1, 8'h10, 8'h33, 8'h07, 8'hA5, n);
        chk("write_latency", last_rsp - n + 1, 2);
        chk("write_keeps_rdata", int'(rsp_rdata), 8'h7F);
        run(2'd0, 8'h10, 8'h00, 8'h00, 8'h00, n);
        chk("readback_rdata", int'(rsp_rdata), 8'hA5);

        // COPY wrapping source
        run(2'd2, 8'hFE, 8'h20, 8'd3, 8'h00, n);
        chk("copy_latency", last_rsp - n + 1, 7);
        chk("copy_mem20", int'(mem[8'h20]), 8'hA4);
        chk("copy_mem21", int'(mem[8'h21]), 8'hA5);
        chk("copy_mem22", int'(mem[8'h22]), 8'h5A);
        chk("copy_rdata", int'(rsp_rdata), 8'h5A);

        // COPY length 0
        run(2'd2, 8'h60, 8'h70, 8'd0, 8'h00, n);
        chk("copy0_latency", last_rsp - n + 1, 1);

        // overlapping COPY, strictly ascending
        run(2'd2, 8'h30, 8'h31, 8'd3, 8'h00, n);
        chk("overlap_mem33", int'(mem[8'h33]), 8'h6A);

        // COPY wrapping destination
        run(2'd2, 8'h50, 8'hFF, 8'd2, 8'h00, n);
        chk("dstwrap_mem00", int'(mem[8'h00]), 8'h0B);

        // FILL
        run(2'd3, 8'h40, 8'h00, 8'd2, 8'h00, n);
`ifdef MEM_DMA_FILL_EN
        chk("fill_latency", last_rsp - n + 1, 3);
        chk("fill_mem40", int'(mem[8'h40]), 8'h00);
        chk("fill_mem41", int'(mem[8'h41]), 8'h00);
`else
        chk("fill_latency", last_rsp - n + 1, 1);
        chk("fill_mem40", int'(mem[8'h40]), 8'h1A);
        chk("fill_mem41", int'(mem[8'h41]), 8'h1B);
`endif

        // reset during the second byte write of a 4-byte COPY
        issue(2'd2, 8'h80, 8'h90, 8'd4, 8'h00, n);
        ref_mem[8'h90] = ref_mem[8'h80];
        wq.push_back({8'h90, ref_mem[8'h80]});
        busy_from = n; busy_to = n + 1000; exp_rsp = -10;
        for (int k = 0; k < 20 && cyc < n + 3; k++) begin @(posedge clk); #1; end
        rst = 1'b1;
        busy_to = -10; exp_rdata = 8'd0;
        #1;
        chk("abort_mem_we", int'(mem_we), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_mem90", int'(mem[8'h90]), 8'hDA);
        chk("abort_mem92", int'(mem[8'h92]), 8'hC8);
        chk("abort_mem93", int'(mem[8'h93]), 8'hC9);

        diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk("mem_image", diff, 0);
        chk("writes_outstanding", wq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
